// File: rtl/arc4_encrypt.sv
// Length-prefixed ARC4 encryption engine: reads {L, data[1..L]} from pt memory and
// writes {L, data ^ keystream} to ct memory, holding the S-box internally.
module arc4_encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [1:0]  km_q, km_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  len_q, len_d;
    logic        rst_q;
    logic [7:0]  s_q [256];

    logic [7:0]  rd_i, s_i, s_j, j_new, t, pad, key_byte;
    logic        s_we;
    logic [7:0]  s_wa, s_da, s_wb, s_db;

    always_comb begin
        case (km_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // PRGA works on i+1 this cycle; INIT/KSA work on i itself.
    assign rd_i  = (state_q == ST_PRGA) ? i_q + 8'd1 : i_q;
    assign s_i   = s_q[rd_i];
    assign j_new = j_q + s_i + ((state_q == ST_KSA) ? key_byte : 8'd0);
    assign s_j   = s_q[j_new];
    assign t     = s_i + s_j;
    assign pad   = (t == rd_i) ? s_j : (t == j_new) ? s_i : s_q[t];

    assign rdy = (state_q == ST_IDLE) && !rst_q && !rst;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        km_d      = km_q;
        key_d     = key_q;
        len_d     = len_q;
        s_we      = 1'b0;
        s_wa      = rd_i;
        s_da      = s_j;
        s_wb      = j_new;
        s_db      = s_i;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && rdy) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    km_d    = 2'd0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                s_we = 1'b1;
                s_wa = i_q;
                s_da = i_q;
                s_wb = i_q;
                s_db = i_q;
                i_d  = i_q + 8'd1;
                if (i_q == 8'd255) state_d = ST_KSA;
            end
            ST_KSA: begin
                s_we = 1'b1;
                j_d  = j_new;
                i_d  = i_q + 8'd1;
                km_d = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
                if (i_q == 8'd255) state_d = ST_LEN;
            end
            ST_LEN: begin
                ct_wren   = 1'b1;
                ct_wrdata = pt_rddata;
                len_d     = pt_rddata;
                i_d       = 8'd0;
                j_d       = 8'd0;
                state_d   = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA;
            end
            ST_PRGA: begin
                s_we      = 1'b1;
                i_d       = rd_i;
                j_d       = j_new;
                pt_addr   = rd_i;
                ct_addr   = rd_i;
                ct_wrdata = pt_rddata ^ pad;
                ct_wren   = 1'b1;
                if (rd_i == len_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are quiet and the S-box untouched while reset is asserted.
        if (rst) begin
            s_we      = 1'b0;
            pt_addr   = 8'd0;
            ct_addr   = 8'd0;
            ct_wrdata = 8'd0;
            ct_wren   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            km_q    <= 2'd0;
            key_q   <= 24'd0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            km_q    <= km_d;
            key_q   <= key_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // NOTE: the S-box has no reset; INIT rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (s_we) begin
            s_q[s_wa] <= s_da;
            s_q[s_wb] <= s_db;
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt: table of runs checked against a software RC4
// model, plus round-trip, busy-ignore, reset and back-to-back sequences.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst, en, rdy, ct_wren;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

    logic [7:0]  pt_mem  [256];
    logic [7:0]  ct_mem  [256];
    logic [7:0]  exp_ct  [256];
    logic [7:0]  save_mem[256];
    logic [7:0]  std_ct  [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                                  8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    logic        clr_ct = 1'b0;
    int          wr_count, order_err;
    logic [7:0]  exp_addr;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [23:0] key;
        int          mode;        // 0 = "Plaintext", 1 = pseudo-random bytes
        int          len;
        int          seed;
        int          exp_cycles;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    assign pt_rddata = pt_mem[pt_addr];

    // ct memory with a sentinel fill, plus write-count and address-order tracking
    always @(posedge clk) begin
        if (clr_ct) begin
            for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hEE;
            wr_count  <= 0;
            exp_addr  <= 8'd0;
            order_err <= 0;
        end else if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            if (ct_addr != exp_addr) order_err <= order_err + 1;
            exp_addr <= exp_addr + 8'd1;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load(input int mode, input int len, input int seed);
        string      txt = "Plaintext";
        logic [7:0] r;
        r = seed[7:0] | 8'h01;
        for (int a = 1; a < 256; a++) begin
            r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
            pt_mem[a] = r;
        end
        if (mode == 0)
            for (int n = 0; n < 9; n++) pt_mem[n + 1] = txt[n];
        pt_mem[0] = len[7:0];
    endtask

    // Textbook RC4 over the current pt memory; bytes past L stay at the sentinel.
    task automatic model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb[3];
        logic [7:0] tmp, t;
        int         i, j, len;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int a = 0; a < 256; a++) begin
            s[a] = a[7:0];
            exp_ct[a] = 8'hEE;
        end
        j = 0;
        for (i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(kb[i % 3])) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
        end
        len = int'(pt_mem[0]);
        exp_ct[0] = pt_mem[0];
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            t = s[i] + s[j];
            exp_ct[n] = pt_mem[n] ^ s[t];
        end
    endtask

    function automatic int diff_ct();
        int d = 0;
        for (int a = 0; a < 256; a++) if (ct_mem[a] !== exp_ct[a]) d++;
        return d;
    endfunction

    // Called on a negedge with rdy=1; returns on the first negedge rdy is high again.
    task automatic run(input logic [23:0] k, input bit busy, output int cycles);
        key    = k;
        en     = 1'b1;
        clr_ct = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            clr_ct = 1'b0;
            cycles++;
            en = busy && (cycles == 100 || cycles == 520);
            if (busy) key = ~k ^ 24'(cycles);
        end while (!rdy && cycles < 2000);
        en = 1'b0;
        if (cycles >= 2000) check("run_timeout_rdy", {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        int cyc, lowc, snap;

        vecs[0] = '{24'h4B6579, 0, 9,   0,  524};
        vecs[1] = '{24'h000155, 1, 255, 3,  770};
        vecs[2] = '{24'hA5A5A5, 1, 0,   5,  515};
        vecs[3] = '{24'h000000, 1, 1,   9,  516};
        vecs[4] = '{24'hFFFFFF, 1, 37,  11, 552};

        rst = 1'b1; en = 1'b0; key = 24'd0;
        load(0, 9, 0);
        @(negedge clk);
        @(negedge clk);
        check("reset_rdy",       {31'd0, rdy},     32'd0);
        check("reset_ct_wren",   {31'd0, ct_wren}, 32'd0);
        check("reset_pt_addr",   {24'd0, pt_addr}, 32'd0);
        check("reset_ct_addr",   {24'd0, ct_addr}, 32'd0);
        check("reset_ct_wrdata", {24'd0, ct_wrdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", {31'd0, rdy}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            load(vecs[v].mode, vecs[v].len, vecs[v].seed);
            model(vecs[v].key);
            run(vecs[v].key, 1'b0, cyc);
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
            check($sformatf("vec%0d_writes", v), wr_count, vecs[v].len + 1);
            check($sformatf("vec%0d_order", v), order_err, 0);
            check($sformatf("vec%0d_ct_diff", v), diff_ct(), 0);
            if (vecs[v].mode == 0)
                for (int n = 0; n < 10; n++)
                    check($sformatf("std_ct[%0d]", n), {24'd0, ct_mem[n]}, {24'd0, std_ct[n]});
        end

        // Round trip: encrypting the ciphertext with the same key restores the plaintext.
        load(1, 255, 77);
        for (int a = 0; a < 256; a++) save_mem[a] = pt_mem[a];
        run(24'h000155, 1'b0, cyc);
        check("rt_first_cycles", cyc, 770);
        for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
        run(24'h000155, 1'b0, cyc);
        for (int a = 0; a < 256; a++) exp_ct[a] = save_mem[a];
        check("rt_restored_diff", diff_ct(), 0);

        // en and key toggled during INIT and PRGA must not disturb the run.
        load(0, 9, 0);
        model(24'h4B6579);
        run(24'h4B6579, 1'b1, cyc);
        check("busy_cycles", cyc, 524);
        check("busy_ct_diff", diff_ct(), 0);
        lowc = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rdy) lowc++;
        end
        check("busy_no_rerun_rdy", lowc, 0);
        check("busy_no_rerun_writes", wr_count, 10);

        // Reset pulse in the middle of PRGA.
        key = 24'h4B6579; en = 1'b1; clr_ct = 1'b1;
        @(negedge clk);
        en = 1'b0; clr_ct = 1'b0;
        for (int c = 1; c < 518; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap = wr_count;
        check("midrst_rdy_low",  {31'd0, rdy},     32'd0);
        check("midrst_ct_wren",  {31'd0, ct_wren}, 32'd0);
        check("midrst_pt_addr",  {24'd0, pt_addr}, 32'd0);
        @(negedge clk);
        check("midrst_rdy_back", {31'd0, rdy}, 32'd1);
        repeat (20) @(negedge clk);
        check("midrst_no_writes", wr_count, snap);
        run(24'h4B6579, 1'b0, cyc);
        check("midrst_rerun_cycles", cyc, 524);
        check("midrst_rerun_diff", diff_ct(), 0);

        // Simultaneous rst and en: reset wins, no run starts.
        rst = 1'b1; en = 1'b1; key = 24'h111111;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        check("rst_en_rdy_low", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        check("rst_en_rdy_back", {31'd0, rdy}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_en_no_run", {31'd0, rdy}, 32'd1);

        // Back-to-back: second en on the first rdy-high cycle with a new key.
        model(24'h4B6579);
        run(24'h4B6579, 1'b0, cyc);
        check("b2b_first_diff", diff_ct(), 0);
        model(24'h000000);
        run(24'h000000, 1'b0, cyc);
        check("b2b_second_cycles", cyc, 524);
        check("b2b_second_diff", diff_ct(), 0);
        check("b2b_second_writes", wr_count, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
